// File: rtl/hazard_dest_pipe.sv
// Destination/flag pipeline (ID->EXE->MEM->WB) for hazard detection,
// plus operand forwarding muxes, writeback data register and event counters.
module hazard_dest_pipe #(
    parameter int AW = 5,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_wreg,
    input  logic          id_mem2reg,
    input  logic          id_wmem,
    input  logic          id_regrt,
    input  logic          id_jal,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic          stall,
    input  logic          id_cancel,
    input  logic [DW-1:0] exe_alu_result,
    input  logic [DW-1:0] mem_load_data,
    input  logic [DW-1:0] rf_a,
    input  logic [DW-1:0] rf_b,
    input  logic [1:0]    fwda,
    input  logic [1:0]    fwdb,
    output logic [AW-1:0] exe_regw_addr,
    output logic          exe_wreg,
    output logic          exe_mem2reg,
    output logic          exe_wmem,
    output logic [AW-1:0] mem_regw_addr,
    output logic          mem_wreg,
    output logic          mem_mem2reg,
    output logic          mem_wmem,
    output logic [DW-1:0] mem_alu_result,
    output logic [AW-1:0] wb_regw_addr,
    output logic          wb_wreg,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] opa,
    output logic [DW-1:0] opb,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] cancel_cnt
);

    localparam logic [AW-1:0] RA_ADDR  = AW'(31);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [AW-1:0] dest;
    logic          dest_wreg;
    logic          bubble;

    assign dest      = id_jal ? RA_ADDR : (id_regrt ? id_rd : id_rt);
    assign dest_wreg = id_wreg && (dest != '0);
    assign bubble    = stall || id_cancel;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_regw_addr <= '0;
            exe_wreg      <= 1'b0;
            exe_mem2reg   <= 1'b0;
            exe_wmem      <= 1'b0;
        end else if (bubble) begin
            exe_regw_addr <= '0;
            exe_wreg      <= 1'b0;
            exe_mem2reg   <= 1'b0;
            exe_wmem      <= 1'b0;
        end else begin
            exe_regw_addr <= dest;
            exe_wreg      <= dest_wreg;
            exe_mem2reg   <= id_mem2reg;
            exe_wmem      <= id_wmem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_regw_addr  <= '0;
            mem_wreg       <= 1'b0;
            mem_mem2reg    <= 1'b0;
            mem_wmem       <= 1'b0;
            mem_alu_result <= '0;
            wb_regw_addr   <= '0;
            wb_wreg        <= 1'b0;
            wb_data        <= '0;
        end else begin
            mem_regw_addr  <= exe_regw_addr;
            mem_wreg       <= exe_wreg;
            mem_mem2reg    <= exe_mem2reg;
            mem_wmem       <= exe_wmem;
            mem_alu_result <= exe_alu_result;
            wb_regw_addr   <= mem_regw_addr;
            wb_wreg        <= mem_wreg;
            wb_data        <= mem_mem2reg ? mem_load_data : mem_alu_result;
        end
    end

    always_comb begin
        opa = rf_a;
        unique case (fwda)
            2'b00: opa = rf_a;
            2'b01: opa = exe_alu_result;
            2'b10: opa = mem_alu_result;
            2'b11: opa = mem_load_data;
            default: opa = rf_a;
        endcase
    end

    always_comb begin
        opb = rf_b;
        unique case (fwdb)
            2'b00: opb = rf_b;
            2'b01: opb = exe_alu_result;
            2'b10: opb = mem_alu_result;
            2'b11: opb = mem_load_data;
            default: opb = rf_b;
        endcase
    end

    // A cancel that coincides with a stall is counted only as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            cancel_cnt <= '0;
        end else begin
            if (stall && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (id_cancel && !stall && cancel_cnt != CNT_MAX)
                cancel_cnt <= cancel_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Directed testbench for hazard_dest_pipe (CW=4 to reach saturation quickly).
module tb_hazard_dest_pipe;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_wreg, id_mem2reg, id_wmem, id_regrt, id_jal;
    logic [AW-1:0] id_rt, id_rd;
    logic          stall, id_cancel;
    logic [DW-1:0] exe_alu_result, mem_load_data, rf_a, rf_b;
    logic [1:0]    fwda, fwdb;
    logic [AW-1:0] exe_regw_addr, mem_regw_addr, wb_regw_addr;
    logic          exe_wreg, exe_mem2reg, exe_wmem;
    logic          mem_wreg, mem_mem2reg, mem_wmem, wb_wreg;
    logic [DW-1:0] mem_alu_result, wb_data, opa, opb;
    logic [CW-1:0] stall_cnt, cancel_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hazard_dest_pipe #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_wmem(id_wmem),
        .id_regrt(id_regrt), .id_jal(id_jal),
        .id_rt(id_rt), .id_rd(id_rd),
        .stall(stall), .id_cancel(id_cancel),
        .exe_alu_result(exe_alu_result), .mem_load_data(mem_load_data),
        .rf_a(rf_a), .rf_b(rf_b), .fwda(fwda), .fwdb(fwdb),
        .exe_regw_addr(exe_regw_addr), .exe_wreg(exe_wreg),
        .exe_mem2reg(exe_mem2reg), .exe_wmem(exe_wmem),
        .mem_regw_addr(mem_regw_addr), .mem_wreg(mem_wreg),
        .mem_mem2reg(mem_mem2reg), .mem_wmem(mem_wmem),
        .mem_alu_result(mem_alu_result),
        .wb_regw_addr(wb_regw_addr), .wb_wreg(wb_wreg), .wb_data(wb_data),
        .opa(opa), .opb(opb),
        .stall_cnt(stall_cnt), .cancel_cnt(cancel_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_nop();
        id_wreg = 0; id_mem2reg = 0; id_wmem = 0;
        id_regrt = 0; id_jal = 0; id_rt = '0; id_rd = '0;
        stall = 0; id_cancel = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".exe_addr"}, 32'(exe_regw_addr), 0);
        check({tag, ".exe_flags"},
              {29'd0, exe_wreg, exe_mem2reg, exe_wmem}, 0);
        check({tag, ".mem_addr"}, 32'(mem_regw_addr), 0);
        check({tag, ".mem_flags"},
              {29'd0, mem_wreg, mem_mem2reg, mem_wmem}, 0);
        check({tag, ".mem_alu"}, mem_alu_result, 0);
        check({tag, ".wb_addr"}, 32'(wb_regw_addr), 0);
        check({tag, ".wb_wreg"}, 32'(wb_wreg), 0);
        check({tag, ".wb_data"}, wb_data, 0);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
        check({tag, ".cancel_cnt"}, 32'(cancel_cnt), 0);
    endtask

    initial begin
        // Random inputs during reset, including stall/cancel asserted.
        rst = 1;
        id_wreg = 1; id_mem2reg = 1; id_wmem = 1;
        id_regrt = 1; id_jal = 0;
        id_rt = AW'($urandom); id_rd = 5'd17;
        stall = 1; id_cancel = 1;
        exe_alu_result = $urandom; mem_load_data = $urandom;
        rf_a = $urandom; rf_b = $urandom;
        fwda = 2'b00; fwdb = 2'b00;
        step();
        check_all_zero("rst1");
        stall = 0; id_cancel = 0;
        step();
        check_all_zero("rst2");

        rst = 0;
        id_nop();
        exe_alu_result = '0; mem_load_data = '0;
        step();
        step();
        step();

        // Propagation: add writing r5
        id_regrt = 1; id_rd = 5'd5; id_wreg = 1;
        exe_alu_result = 32'h55;
        step();
        check("prop.exe_addr", 32'(exe_regw_addr), 5);
        check("prop.exe_wreg", 32'(exe_wreg), 1);
        id_nop();
        step();
        check("prop.mem_addr", 32'(mem_regw_addr), 5);
        check("prop.mem_wreg", 32'(mem_wreg), 1);
        check("prop.mem_alu", mem_alu_result, 32'h55);
        exe_alu_result = '0;
        step();
        check("prop.wb_addr", 32'(wb_regw_addr), 5);
        check("prop.wb_wreg", 32'(wb_wreg), 1);
        check("prop.wb_data", wb_data, 32'h55);

        // jal to r31
        id_jal = 1; id_wreg = 1; id_rd = 5'd3; id_rt = 5'd4;
        step();
        check("jal.exe_addr", 32'(exe_regw_addr), 31);
        check("jal.exe_wreg", 32'(exe_wreg), 1);

        // r0 write suppression
        id_nop();
        id_wreg = 1; id_rt = 5'd0; id_rd = 5'd9;
        step();
        check("r0.exe_wreg", 32'(exe_wreg), 0);
        check("r0.exe_addr", 32'(exe_regw_addr), 0);

        // Load to r8, then dependent instruction stalled
        id_nop();
        id_rt = 5'd8; id_wreg = 1; id_mem2reg = 1;
        step();
        check("lw.exe_addr", 32'(exe_regw_addr), 8);
        check("lw.exe_m2r", 32'(exe_mem2reg), 1);
        id_nop();
        id_regrt = 1; id_rd = 5'd9; id_rt = 5'd8;
        id_wreg = 1; id_mem2reg = 1; id_wmem = 1;
        stall = 1;
        step();
        check("lu.bubble_addr", 32'(exe_regw_addr), 0);
        check("lu.bubble_flags",
              {29'd0, exe_wreg, exe_mem2reg, exe_wmem}, 0);
        check("lu.stall_cnt", 32'(stall_cnt), 1);
        check("lu.mem_addr", 32'(mem_regw_addr), 8);
        check("lu.mem_m2r", 32'(mem_mem2reg), 1);
        stall = 0;
        mem_load_data = 32'hDEADBEEF;
        fwda = 2'b11;
        #1;
        check("lu.opa_fwd", opa, 32'hDEADBEEF);
        step();
        check("lu.wb_data", wb_data, 32'hDEADBEEF);
        check("lu.wb_addr", 32'(wb_regw_addr), 8);
        check("lu.wb_wreg", 32'(wb_wreg), 1);

        // Forwarding mux sweep
        id_nop();
        exe_alu_result = 32'd3;
        step();
        check("fw.mem_alu", mem_alu_result, 3);
        exe_alu_result = 32'd2;
        rf_a = 32'd1; rf_b = 32'd11;
        mem_load_data = 32'd4;
        for (int i = 0; i < 4; i++) begin
            fwda = 2'(i);
            fwdb = 2'(3 - i);
            #1;
            check($sformatf("fw.opa%0d", i), opa, 32'(i + 1));
            check($sformatf("fw.opb%0d", i), opb,
                  (i == 3) ? 32'd11 : 32'(4 - i));
        end
        fwda = 2'b00; fwdb = 2'b00;

        // Cancel suppresses a store
        id_nop();
        id_regrt = 1; id_rd = 5'd12; id_wreg = 1; id_wmem = 1;
        id_cancel = 1;
        step();
        check("cx.exe_wmem", 32'(exe_wmem), 0);
        check("cx.exe_wreg", 32'(exe_wreg), 0);
        check("cx.cancel_cnt", 32'(cancel_cnt), 1);
        check("cx.stall_cnt", 32'(stall_cnt), 1);

        // Stall and cancel together: one bubble, counted as a stall
        stall = 1;
        step();
        check("sc.exe_wmem", 32'(exe_wmem), 0);
        check("sc.cancel_cnt", 32'(cancel_cnt), 1);
        check("sc.stall_cnt", 32'(stall_cnt), 2);

        // Saturation with CW=4
        id_cancel = 0;
        for (int i = 0; i < 20; i++) step();
        check("sat.stall_cnt", 32'(stall_cnt), 15);
        check("sat.cancel_cnt", 32'(cancel_cnt), 1);

        // Reset mid-flight discards the write in progress
        id_nop();
        id_regrt = 1; id_rd = 5'd7; id_wreg = 1;
        exe_alu_result = 32'h77;
        step();
        check("mid.exe_addr", 32'(exe_regw_addr), 7);
        id_nop();
        rst = 1;
        step();
        rst = 0;
        check_all_zero("mid");
        step();
        check("mid.wb_wreg1", 32'(wb_wreg), 0);
        step();
        check("mid.wb_wreg2", 32'(wb_wreg), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
